// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller.
//   NUM_SRC     : number of interrupt source lines
//   ID_W        : width of a source index
//   irq_state_t : controller FSM states
package irq_pkg;
    localparam int NUM_SRC = 8;
    localparam int ID_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQUEST = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;
endpackage

// File: rtl/irq_priority_enc.sv
// Combinational find-first: reports the lowest set index of req.
//   req   : request vector, bit 0 is highest priority
//   valid : any bit of req set
//   id    : index of the lowest set bit (0 when valid is low)
module irq_priority_enc
    import irq_pkg::*;
#(
    parameter int N = NUM_SRC,
    parameter int W = ID_W
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] id
);
    always_comb begin
        valid = |req;
        id    = '0;
        // Walk downwards so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) id = W'(i);
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Single-level interrupt controller: per-source rising-edge capture into a
// pending register, maskable fixed-priority arbitration, and a
// request/service handshake with the processor (no nesting).
//   clk, reset            : clock, asynchronous active-low reset
//   irq_src               : level source lines (edge-detected internally)
//   mask_we, mask_wdata   : mask register write port
//   irq_ack, irq_done     : processor trap taken / handler finished
//   irq_req, irq_id       : request to processor and the latched winner
//   irq_mask, irq_pending : register visibility
//   busy                  : request or service in progress
module irq_controller
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] irq_mask,
    output logic [NUM_SRC-1:0] irq_pending,
    output logic               busy
);
    irq_state_t         state;
    logic [NUM_SRC-1:0] prev_src;
    logic [NUM_SRC-1:0] edge_vec;
    logic [NUM_SRC-1:0] clr_vec;
    logic               take;
    logic               enc_valid;
    logic [ID_W-1:0]    enc_id;

    assign edge_vec = irq_src & ~prev_src;
    assign take     = (state == ST_REQUEST) && irq_ack;
    // Clear is applied before the set, so a coincident new edge wins.
    assign clr_vec  = take ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id) : '0;

    // Masked sources keep latching but never reach the arbiter.
    irq_priority_enc #(.N(NUM_SRC), .W(ID_W)) u_enc (
        .req   (irq_pending & irq_mask),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            prev_src    <= '0;
            irq_pending <= '0;
            irq_mask    <= '0;
            irq_id      <= '0;
        end else begin
            prev_src    <= irq_src;
            irq_pending <= (irq_pending & ~clr_vec) | edge_vec;
            if (mask_we) irq_mask <= mask_wdata;
            case (state)
                // irq_id only loads here, so it holds through REQUEST/SERVICE.
                ST_IDLE: if (enc_valid) begin
                    state  <= ST_REQUEST;
                    irq_id <= enc_id;
                end
                // ack takes precedence over a simultaneous done.
                ST_REQUEST: if (irq_ack)  state <= ST_SERVICE;
                ST_SERVICE: if (irq_done) state <= ST_IDLE;
                default:                  state <= ST_IDLE;
            endcase
        end
    end

    assign irq_req = (state == ST_REQUEST);
    assign busy    = (state != ST_IDLE);
endmodule
